// File: rtl/serial_adder_ctrl_if.sv
// serial_adder_ctrl_if: operand/result handshake bundle; SERIAL_ADDER_SUB_EN adds the sub select
interface serial_adder_ctrl_if #(parameter int WIDTH = 8);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             busy;
  modport master (
    output in_valid, a, b, c_in,
`ifdef SERIAL_ADDER_SUB_EN
    output sub,
`endif
    output out_ready,
    input  in_ready, out_valid, sum, c_out, busy
  );
  modport slave (
    input  in_valid, a, b, c_in,
`ifdef SERIAL_ADDER_SUB_EN
    input  sub,
`endif
    input  out_ready,
    output in_ready, out_valid, sum, c_out, busy
  );
endinterface

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial LSB-first adder sharing one full adder; SERIAL_ADDER_SUB_EN enables a - b
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input logic               clk,
  input logic               rst_n,
  serial_adder_ctrl_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh, b_sh, sum_sh, sum_q, sum_nx, b_ld;
  logic [CW-1:0]    cnt;
  logic             carry, c_out_q, c_ld, fa_sum, fa_carry, last;
`ifdef SERIAL_ADDER_SUB_EN
  assign b_ld = bus.sub ? ~bus.b : bus.b;
  assign c_ld = bus.sub | bus.c_in;
`else
  assign b_ld = bus.b;
  assign c_ld = bus.c_in;
`endif
  assign fa_sum   = a_sh[0] ^ b_sh[0] ^ carry;
  assign fa_carry = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));
  assign last     = cnt == CW'(WIDTH - 1);
  // new bit enters at the MSB; the shift form stays legal for WIDTH=1
  assign sum_nx   = (sum_sh >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));
  assign bus.sum   = sum_q;
  assign bus.c_out = c_out_q;
  always_comb begin
    state_d       = state_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    state_d       = state_q == IDLE ? (bus.in_valid ? RUN : IDLE)
                  : state_q == RUN  ? (last ? DONE : RUN)
                  : bus.out_ready   ? IDLE : DONE;
    bus.in_ready  = state_q == IDLE;
    bus.out_valid = state_q == DONE;
    bus.busy      = state_q == RUN;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh    <= '0;
      b_sh    <= '0;
      sum_sh  <= '0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
      carry   <= 1'b0;
      cnt     <= '0;
    end else if (state_q == IDLE && bus.in_valid) begin
      a_sh  <= bus.a;
      b_sh  <= b_ld;
      carry <= c_ld;
      cnt   <= '0;
    end else if (state_q == RUN) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      sum_sh <= sum_nx;
      carry  <= fa_carry;
      cnt    <= cnt + CW'(1);
      if (last) begin
        sum_q   <= sum_nx;
        c_out_q <= fa_carry;
      end
    end
  end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: scoreboard bench for WIDTH=8 and WIDTH=1 instances
module tb_serial_adder_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  logic [64:0] q8[$];
  logic [64:0] q1[$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  serial_adder_ctrl_if #(.WIDTH(8)) b8();
  serial_adder_ctrl_if #(.WIDTH(1)) b1();
  serial_adder_ctrl #(.WIDTH(8)) u8 (.clk(clk), .rst_n(rst_n), .bus(b8));
  serial_adder_ctrl #(.WIDTH(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // reference: plain unsigned arithmetic, result packed as {c_out, sum}
  function automatic logic [64:0] model(input int w, input logic [63:0] a, input logic [63:0] b,
                                        input logic ci, input logic s);
    logic [64:0] m;
    m = (65'd1 << w) - 65'd1;
    if (s) return ({64'd0, a >= b} << w) | ((65'(a) - 65'(b)) & m);
    return (65'(a) + 65'(b) + 65'(ci)) & ((m << 1) | 65'd1);
  endfunction
  always @(negedge clk)
    if (rst_n && b8.out_valid && b8.out_ready) begin
      if (q8.size() == 0) check("w8_unexpected_out", 65'd1, 65'd0);
      else check("w8_result", 65'({b8.c_out, b8.sum}), q8.pop_front());
    end
  always @(negedge clk)
    if (rst_n && b1.out_valid && b1.out_ready) begin
      if (q1.size() == 0) check("w1_unexpected_out", 65'd1, 65'd0);
      else check("w1_result", 65'({b1.c_out, b1.sum}), q1.pop_front());
    end
  task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic ci, input logic s);
    int n = 0;
    b8.in_valid = 1'b1; b8.a = a; b8.b = b; b8.c_in = ci;
`ifdef SERIAL_ADDER_SUB_EN
    b8.sub = s;
`endif
    @(negedge clk);
    while (!b8.in_ready && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin
      check("w8_accept_timeout", 65'(n), 65'd0);
      b8.in_valid = 1'b0;
      return;
    end
    q8.push_back(model(8, 64'(a), 64'(b), ci, s));
    @(posedge clk);
    acc_cyc = cyc;
    #1 b8.in_valid = 1'b0;
  endtask
  task automatic send1(input logic a, input logic b, input logic ci, input logic s);
    int n = 0;
    b1.in_valid = 1'b1; b1.a = a; b1.b = b; b1.c_in = ci;
`ifdef SERIAL_ADDER_SUB_EN
    b1.sub = s;
`endif
    @(negedge clk);
    while (!b1.in_ready && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin
      check("w1_accept_timeout", 65'(n), 65'd0);
      b1.in_valid = 1'b0;
      return;
    end
    q1.push_back(model(1, 64'(a), 64'(b), ci, s));
    @(posedge clk);
    #1 b1.in_valid = 1'b0;
  endtask
  task automatic wait_valid8(output int n);
    n = 0;
    while (!b8.out_valid && n < 50) begin @(posedge clk); #1; n++; end
  endtask
  initial begin
    int n, acc1;
    logic s, seen;
    logic [64:0] e;
    b8.in_valid = 0; b8.a = 0; b8.b = 0; b8.c_in = 0; b8.out_ready = 1;
    b1.in_valid = 0; b1.a = 0; b1.b = 0; b1.c_in = 0; b1.out_ready = 1;
`ifdef SERIAL_ADDER_SUB_EN
    b8.sub = 0; b1.sub = 0;
`endif
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_in_ready", 65'(b8.in_ready), 65'd1);
    check("rst_out_valid", 65'(b8.out_valid), 65'd0);
    check("rst_busy", 65'(b8.busy), 65'd0);
    check("rst_sum_cout", 65'({b8.c_out, b8.sum}), 65'd0);
    send8(8'h5A, 8'h3C, 1'b0, 1'b0);
    check("run_busy", 65'(b8.busy), 65'd1);
    check("run_in_ready", 65'(b8.in_ready), 65'd0);
    wait_valid8(n);
    check("latency_w8", 65'(n), 65'd8);
    check("t1_sum_cout", 65'({b8.c_out, b8.sum}), 65'h096);
    @(posedge clk); #1;
    check("t1_valid_one_cycle", 65'(b8.out_valid), 65'd0);
    send8(8'hFF, 8'h01, 1'b0, 1'b0);
    send8(8'hFF, 8'h00, 1'b1, 1'b0);
    send8(8'h00, 8'h00, 1'b0, 1'b0);
    wait_valid8(n);
    @(posedge clk); #1;
    b8.out_ready = 1'b0;
    send8(8'hC3, 8'h7E, 1'b1, 1'b0);
    e = model(8, 64'hC3, 64'h7E, 1'b1, 1'b0);
    wait_valid8(n);
    repeat (5) begin
      check("stall_out_valid", 65'(b8.out_valid), 65'd1);
      check("stall_sum_cout", 65'({b8.c_out, b8.sum}), e);
      check("stall_in_ready", 65'(b8.in_ready), 65'd0);
      @(posedge clk); #1;
    end
    b8.out_ready = 1'b1;
    @(posedge clk); #1;
    check("stall_release_idle", 65'(b8.in_ready), 65'd1);
    send8(8'h12, 8'h34, 1'b0, 1'b0);
    acc1 = acc_cyc;
    send8(8'hAB, 8'hCD, 1'b1, 1'b0);
    check("hold_valid_spacing", 65'(acc_cyc - acc1), 65'd10);
    wait_valid8(n);
    @(posedge clk); #1;
    send8(8'h77, 8'h88, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    void'(q8.pop_back());
    @(posedge clk);
    #1 rst_n = 1'b1;
    check("midrun_rst_in_ready", 65'(b8.in_ready), 65'd1);
    check("midrun_rst_out_valid", 65'(b8.out_valid), 65'd0);
    check("midrun_rst_sum_cout", 65'({b8.c_out, b8.sum}), 65'd0);
    seen = 1'b0;
    repeat (12) begin @(posedge clk); #1; seen |= b8.out_valid; end
    check("midrun_rst_no_stale", 65'(seen), 65'd0);
`ifdef SERIAL_ADDER_SUB_EN
    send8(8'h10, 8'h01, 1'b0, 1'b1);
    wait_valid8(n);
    check("sub_10_01", 65'({b8.c_out, b8.sum}), 65'h10F);
    @(posedge clk); #1;
    send8(8'h00, 8'h01, 1'b1, 1'b1);
    wait_valid8(n);
    check("sub_00_01", 65'({b8.c_out, b8.sum}), 65'h0FF);
    @(posedge clk); #1;
`endif
    seen = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          s = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
          s = 1'($urandom_range(0, 1));
`endif
          send8(8'($urandom), 8'($urandom), 1'($urandom), s);
        end
        n = 0;
        while (q8.size() != 0 && n < 2000) begin @(posedge clk); n++; end
        seen = 1'b1;
      end
      begin
        while (!seen) begin @(posedge clk); #1 b8.out_ready = $urandom_range(0, 3) != 0; end
      end
    join
    b8.out_ready = 1'b1;
    check("w8_drain", 65'(q8.size()), 65'd0);
    send1(1'b1, 1'b1, 1'b1, 1'b0);
    n = 0;
    while (!b1.out_valid && n < 20) begin @(posedge clk); #1; n++; end
    check("latency_w1", 65'(n), 65'd1);
    check("w1_111", 65'({b1.c_out, b1.sum}), 65'b11);
    @(posedge clk); #1;
    for (int i = 0; i < 30; i++) begin
      s = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
      s = 1'($urandom_range(0, 1));
`endif
      send1(1'($urandom), 1'($urandom), 1'($urandom), s);
    end
    n = 0;
    while (q1.size() != 0 && n < 100) begin @(posedge clk); n++; end
    check("w1_drain", 65'(q1.size()), 65'd0);
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
Bit-serial add engine: one full_adder instance is time-shared over a WIDTH-bit word, LSB first, one bit per clock. A controller FSM handles the valid/ready handshakes, the operand shift registers, the carry flip-flop and the bit counter. It is used where area matters more than latency, in place of a WIDTH-wide ripple adder.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 1..64.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst_n  input  1  synchronous active-low reset, sampled on the clk rising edge.
in_valid  input  1  operands a, b, c_in are valid.
in_ready  output  1  block accepts operands this cycle.
a  input  WIDTH  operand A.
b  input  WIDTH  operand B.
c_in  input  1  carry-in.
out_valid  output  1  sum and c_out are valid.
out_ready  input  1  consumer takes the result this cycle.
sum  output  WIDTH  result.
c_out  output  1  carry-out of the MSB.
busy  output  1  high in RUN.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low (rst_n), sampled on the clk rising edge. A reset on any edge wins over every other event.
- Reset values: state=IDLE, in_ready=1 (combinational from state), out_valid=0, busy=0, sum=0, c_out=0, carry FF=0, counter=0, shift registers=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: a_sh<=a, b_sh<=b, carry<=c_in, cnt<=0, go to RUN.
  - in_valid is ignored in every other state (in_ready=0).
- RUN, per cycle:
  - fa inputs: a_sh[0], b_sh[0], carry.
  - sum_sh <= {fa.sum, sum_sh[WIDTH-1:1]}; a_sh and b_sh shift right by 1.
  - carry <= fa.carry; cnt <= cnt+1.
  - When cnt==WIDTH-1: the last bit is processed this cycle; sum <= final shifted value, c_out <= fa.carry, go to DONE.
  - Counter width is $clog2(WIDTH)+1; no wrap occurs. WIDTH=1 spends exactly one RUN cycle.
- DONE:
  - out_valid=1; sum and c_out held stable while out_ready=0, with no limit on the stall.
  - On out_ready: out_valid<=0, go to IDLE.
  - in_ready stays 0 in DONE; there is no same-cycle accept, so minimum spacing between accepts is WIDTH+2 cycles.
- Latency: out_valid rises on the WIDTH-th rising edge after the accepting edge (WIDTH=8: 8 edges).
- sum/c_out keep their last value in IDLE. They are meaningful only while out_valid=1.
- Reset mid-RUN or mid-DONE: partial result discarded, all reset values apply on that edge, and in_ready=1 in the following cycle.
- Arithmetic: {c_out,sum} = a + b + c_in mod 2^(WIDTH+1), unsigned.

Optional Feature:
SERIAL_ADDER_SUB_EN
- Defined:
  - Adds input port sub (1 bit), sampled together with the operands at accept.
  - sub=1: b_sh<=~b, carry<=1, c_in ignored; result = a - b, with c_out=1 meaning no borrow.
  - sub=0: behaviour identical to add mode.
- Undefined: port sub is absent; add-only.
- Latency and handshake are unchanged in both builds.

Test Plan:
1. WIDTH=8, a=0x5A, b=0x3C, c_in=0, out_ready=1 -> sum=0x96, c_out=0; out_valid rises exactly 8 edges after accept and is high for 1 cycle.
2. a=0xFF, b=0x01, c_in=0 -> sum=0x00, c_out=1. Then a=0xFF, b=0x00, c_in=1 -> sum=0x00, c_out=1. Then a=0, b=0, c_in=0 -> sum=0x00, c_out=0.
3. Backpressure: out_ready=0 for 5 cycles after out_valid -> sum/c_out stable, in_ready=0 throughout; out_ready=1 -> IDLE the next cycle, new accept possible.
4. in_valid held high during RUN with different operands -> ignored; the first result is unaffected; the second op is accepted only after the DONE handshake.
5. rst_n=0 for one edge when cnt=3 -> next cycle in_ready=1, out_valid=0, sum=0, c_out=0; no stale out_valid ever appears.
6. With SERIAL_ADDER_SUB_EN: sub=1, a=0x10, b=0x01 -> sum=0x0F, c_out=1. sub=1, a=0x00, b=0x01 -> sum=0xFF, c_out=0. Random add/sub mix checked against a reference model, also at WIDTH=1.
